// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming(7,4) receiver.
//   - FSM state encoding for the receive sequencer
//   - codeword bit positions (code[0] is Hamming position 1)
//   - saturation limit of the corrected-error counter
//   - helper that pulls the four data bits out of a codeword
package hamming_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DEC  = 2'd1,
    ST_OUT  = 2'd2
  } rx_state_t;

  // Parity bits sit at the power-of-two Hamming positions 1, 2, 4.
  localparam int P0_POS = 0;
  localparam int P1_POS = 1;
  localparam int P2_POS = 3;

  // Data bits d0..d3 occupy the remaining positions 3, 5, 6, 7.
  localparam int D0_POS = 2;
  localparam int D1_POS = 4;
  localparam int D2_POS = 5;
  localparam int D3_POS = 6;

  localparam int CODE_W  = 7;
  localparam int DATA_W  = 4;
  localparam int COUNT_W = 7;

  localparam logic [COUNT_W-1:0] COUNT_MAX = 7'd127;

  function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] code);
    return {code[D3_POS], code[D2_POS], code[D1_POS], code[D0_POS]};
  endfunction

endpackage

// File: rtl/hamming74_correct.sv
// Combinational Hamming(7,4) single-error corrector.
// Ports:
//   code      [6:0] received codeword (code[0] = Hamming position 1)
//   corrected [6:0] codeword with the syndrome-indicated bit inverted
//   err             1 when the syndrome is non-zero (a bit was corrected)
// Double errors alias onto a single-bit syndrome and are miscorrected;
// that is inherent to plain Hamming(7,4).
module hamming74_correct
  import hamming_pkg::*;
(
  input  logic [6:0] code,
  output logic [6:0] corrected,
  output logic       err
);

  logic [2:0] syndrome;
  logic [6:0] flip_mask;

  // Each syndrome bit covers the positions whose index has that bit set.
  assign syndrome[0] = code[P0_POS] ^ code[D0_POS] ^ code[D1_POS] ^ code[D3_POS];
  assign syndrome[1] = code[P1_POS] ^ code[D0_POS] ^ code[D2_POS] ^ code[D3_POS];
  assign syndrome[2] = code[P2_POS] ^ code[D1_POS] ^ code[D2_POS] ^ code[D3_POS];

  // The syndrome is the 1-based position of the bad bit.
  always_comb begin
    flip_mask = '0;
    if (syndrome != 3'd0) begin
      flip_mask[syndrome - 3'd1] = 1'b1;
    end
  end

  assign corrected = code ^ flip_mask;
  assign err       = (syndrome != 3'd0);

endmodule

// File: rtl/tt_um_sowmya_hamming_rx.sv
// Hamming(7,4) receiver: captures a strobed 7-bit codeword, corrects any
// single-bit error and presents the data with status flags and a
// saturating count of corrected words.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   ena         power indicator, not used
//   ui_in       [6:0] codeword, [7] word strobe (asynchronous)
//   uo_out      [3:0] data, [4] valid pulse, [5] corrected flag,
//               [6] sticky overrun, [7] new-word toggle
//   uio_in      [7] asynchronous clear of count and overrun
//   uio_out     [6:0] corrected-error count, [7] zero
//   uio_oe      constant 8'h7F
// Handshake: uo_out[4] is a one-cycle valid with no back-pressure; data,
// flag, count and toggle are stable from that cycle until the next word.
// A strobe edge seen while a word is still in flight is dropped and
// latched in the overrun flag.
module tt_um_sowmya_hamming_rx
  import hamming_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  rx_state_t            state;
  logic                 strobe_s1, strobe_s2, strobe_s3;
  logic                 clr_s1, clr_s2;
  logic                 strobe_edge;
  logic [CODE_W-1:0]    cap_q;
  logic [CODE_W-1:0]    corr_q;
  logic                 corr_err_q;
  logic [CODE_W-1:0]    fix_code;
  logic                 fix_err;
  logic [DATA_W-1:0]    data_q;
  logic                 valid_q;
  logic                 err_q;
  logic                 overrun_q;
  logic                 toggle_q;
  logic [COUNT_W-1:0]   count_q;

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in[6:0]};

  // Strobe: two-flop synchronizer plus a history flop for edge detect.
  // Clear: two-flop synchronizer, used as a level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_s1 <= 1'b0;
      strobe_s2 <= 1'b0;
      strobe_s3 <= 1'b0;
      clr_s1    <= 1'b0;
      clr_s2    <= 1'b0;
    end else begin
      strobe_s1 <= ui_in[7];
      strobe_s2 <= strobe_s1;
      strobe_s3 <= strobe_s2;
      clr_s1    <= uio_in[7];
      clr_s2    <= clr_s1;
    end
  end

  assign strobe_edge = strobe_s2 & ~strobe_s3;

  hamming74_correct u_correct (
    .code      (cap_q),
    .corrected (fix_code),
    .err       (fix_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cap_q      <= '0;
      corr_q     <= '0;
      corr_err_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      overrun_q  <= 1'b0;
      toggle_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (strobe_edge) begin
            cap_q <= ui_in[6:0];
            state <= ST_DEC;
          end
        end
        ST_DEC: begin
          corr_q     <= fix_code;
          corr_err_q <= fix_err;
          state      <= ST_OUT;
        end
        ST_OUT: begin
          data_q   <= extract_data(corr_q);
          err_q    <= corr_err_q;
          valid_q  <= 1'b1;
          toggle_q <= ~toggle_q;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // Clear sits last so it overrides an increment or overrun set
      // happening in the same cycle.
      if (state == ST_OUT && corr_err_q && count_q != COUNT_MAX) begin
        count_q <= count_q + 7'd1;
      end
      if (strobe_edge && state != ST_IDLE) begin
        overrun_q <= 1'b1;
      end
      if (clr_s2) begin
        count_q   <= '0;
        overrun_q <= 1'b0;
      end
    end
  end

  assign uo_out  = {toggle_q, overrun_q, err_q, valid_q, data_q};
  assign uio_out = {1'b0, count_q};
  assign uio_oe  = 8'h7F;

endmodule

// File: doc/tt_um_sowmya_hamming_rx.md
TT_UM_SOWMYA_HAMMING_RX -- requirements
Module: tt_um_sowmya_hamming_rx

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset; the ports are listed below.
REQ-002 clk  input  1  system clock; all flops rising-edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 ena  input  1  powered indicator; functionally ignored.
REQ-005 ui_in  input  8  [6:0] received Hamming(7,4) codeword, [7] word strobe (asynchronous to clk).
REQ-006 uo_out  output  8  [3:0] corrected data, [4] valid pulse, [5] corrected-error flag, [6] sticky overrun, [7] new-word toggle.
REQ-007 uio_in  input  8  [7] counter/overrun clear (asynchronous level); [6:0] ignored.
REQ-008 uio_out  output  8  [6:0] corrected-error count, [7] driven 0.
REQ-009 uio_oe  output  8  constant 8'h7F.

Function
REQ-010 The codeword layout SHALL be positions 1..7 = code[0..6], with data d3..d0 = code[6],code[5],code[4],code[2] and parity in code[0],code[1],code[3].
REQ-011 Syndrome SHALL be s0=c0^c2^c4^c6, s1=c1^c2^c5^c6, s2=c3^c4^c5^c6, and S={s2,s1,s0}.
REQ-012 S!=0 SHALL invert code[S-1]; S==0 SHALL pass the word unchanged; double errors are not detected.
REQ-013 ui_in[7] SHALL pass through a 2-flop synchronizer plus an edge flop; edge = sync2 & ~sync3.
REQ-014 The FSM SHALL have states IDLE, DEC and OUT, and SHALL reset to IDLE.
REQ-015 In IDLE with edge=1, the FSM SHALL register ui_in[6:0] into the capture register and go to DEC.
REQ-016 In DEC, the FSM SHALL register the corrected word and (S!=0) and go to OUT.
REQ-017 In OUT, the FSM SHALL update the uo_out[3:0] and [5] registers, pulse [4] for one cycle, toggle [7] and go to IDLE.
REQ-018 Latency: for a strobe rising before clk edge k, capture SHALL occur at k+2 and outputs SHALL update at k+4.
REQ-019 The codeword SHALL be held stable by the sender from k-1 through k+2.
REQ-020 An edge arriving in DEC or OUT SHALL be dropped and SHALL set uo_out[6] sticky.
REQ-021 uo_out[3:0] and [5] SHALL hold between words.
REQ-022 The count SHALL increment in OUT when S!=0, saturating at 127.
REQ-023 uio_in[7] SHALL be synchronized by 2 flops; while the synchronized value is high, it SHALL zero the count and overrun.
REQ-024 Clear SHALL win over an increment or an overrun set in the same cycle.
REQ-025 Clear SHALL NOT affect the FSM or the data outputs.

Reset
REQ-026 rst_n low SHALL immediately force the following: FSM=IDLE, synchronizer/edge flops=0, capture/corrected registers=0, uo_out=8'h00, uio_out=8'h00.
REQ-027 Reset during DEC or OUT SHALL abort the word with no output update.
REQ-028 The first edge after reset release SHALL be a 0->1 strobe transition.

Structure
REQ-029 The shared package hamming_pkg SHALL hold the state encodings, the codeword/data bit-position constants and COUNT_MAX=127.
REQ-030 Syndrome and correction logic SHALL reside in one combinational sub-module, hamming74_correct: 7-bit in, 7-bit corrected out, 1-bit err.
REQ-031 Only registered values SHALL drive the outputs.

Verification
REQ-032 Clean word: code 7'h55 with strobe -> at k+4 data=4'hB, err=0, valid pulse of 1 cycle, toggle=1, count=0.
REQ-033 Single error: 7'h45 (bit 4 flipped) -> data=4'hB, err=1, count=1; each single-bit flip of 7'h55 -> data=4'hB.
REQ-034 Overrun: a second strobe edge detected 1 cycle after capture -> the word is dropped, uo_out[6]=1 and only one valid pulse occurs.
REQ-035 Saturation and clear: 130 corrupted words -> count=127; clear asserted in the same cycle as an increment -> count=0 and overrun=0.
REQ-036 Reset mid-DEC: rst_n low for 1 cycle -> uo_out=0 and no valid pulse; the next strobe decodes normally.
